// File: rtl/playfield_ctrl.sv
// -----------------------------------------------------------------------------
// playfield_ctrl
//
// Purpose:
//   This block drives the "light moves between two players" playfield. Each raw
//   player key is synchronized and turned into a one-cycle press pulse. A
//   left press moves the lit LED one place left and a right press moves it one
//   place right. A press made while the light sits on an end LED is the
//   winning press, and it locks the field until the win/score block issues
//   gameReset.
//
// Optional feature:
//   `define CPU_PLAYER_EN adds a computer right-hand player. This adds the SW
//   difficulty input, a 10-bit Fibonacci LFSR (taps 10,7) and a tick counter
//   that wraps every CPU_PERIOD cycles. On a tick cycle where {1'b0,SW} > LFSR,
//   a one-cycle CPU press is ORed into Rpress.
//
// Parameters:
//   CENTER      - light position after reset or recenter (1..7)
//   CPU_PERIOD  - cycles between CPU press attempts (CPU_PLAYER_EN only, >= 2)
//
// Ports:
//   Clock        in   rising-edge system clock
//   Reset        in   asynchronous, active-low reset
//   L, R         in   raw player keys, high = pressed, asynchronous to Clock
//   gameReset    in   one-cycle recenter request
//   SW[8:0]      in   CPU difficulty (CPU_PLAYER_EN only)
//   LED[8:0]     out  one-hot playfield, LED[8] leftmost, LED[0] rightmost
//   P1LED9       out  LED[8]
//   P2LED1       out  LED[0]
//   Lpress       out  conditioned left press pulse
//   Rpress       out  conditioned right press pulse (key or CPU)
//   o_dbg_state  out  FSM state for observation: 0 = PLAY, 1 = LOCK
// -----------------------------------------------------------------------------
module playfield_ctrl #(
  parameter int CENTER     = 4,
  parameter int CPU_PERIOD = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       L,
  input  logic       R,
  input  logic       gameReset,
`ifdef CPU_PLAYER_EN
  input  logic [8:0] SW,
`endif
  output logic [8:0] LED,
  output logic       P1LED9,
  output logic       P2LED1,
  output logic       Lpress,
  output logic       Rpress,
  output logic       o_dbg_state
);

  // Reject parameter values the design cannot honour.
  if (CENTER < 1 || CENTER > 7 || CPU_PERIOD < 2) begin : g_bad_param
    $error("playfield_ctrl: CENTER must be 1..7 and CPU_PERIOD must be >= 2");
  end

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [3:0] POS_CENTER = 4'(CENTER);
  localparam logic [3:0] POS_MAX    = 4'd8;

  // Key conditioning: 2-flop synchronizer plus previous-value flop.
  logic r_l_s1, r_l_s2, r_l_prev;
  logic r_r_s1, r_r_s2, r_r_prev;
  // The arm counter keeps pulses disabled until prev has captured a settled
  // synchronizer output. Without it, a key held through reset release would
  // look like a fresh rising edge.
  logic [1:0] r_arm_cnt;
  logic       w_armed;
  logic       w_lpress;
  logic       w_rpress_key;
  logic       w_cpu_press;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_pos,   w_pos_nxt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_l_s1    <= 1'b0;
      r_l_s2    <= 1'b0;
      r_l_prev  <= 1'b0;
      r_r_s1    <= 1'b0;
      r_r_s2    <= 1'b0;
      r_r_prev  <= 1'b0;
      r_arm_cnt <= 2'd0;
    end else begin
      r_l_s1    <= L;
      r_l_s2    <= r_l_s1;
      r_l_prev  <= r_l_s2;
      r_r_s1    <= R;
      r_r_s2    <= r_r_s1;
      r_r_prev  <= r_r_s2;
      if (r_arm_cnt != 2'd3) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
    end
  end

  assign w_armed      = (r_arm_cnt == 2'd3);
  assign w_lpress     = w_armed & r_l_s2 & ~r_l_prev;
  assign w_rpress_key = w_armed & r_r_s2 & ~r_r_prev;

`ifdef CPU_PLAYER_EN
  localparam int CNT_W = $clog2(CPU_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPU_PERIOD - 1);

  logic [9:0]       r_lfsr;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_lfsr     <= 10'h001;
      r_tick_cnt <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign w_tick      = (r_tick_cnt == CNT_LAST);
  // Larger SW means a larger share of LFSR values lose the compare,
  // so the CPU presses more often. SW = 0 can never win.
  assign w_cpu_press = w_tick & ({1'b0, SW} > r_lfsr);
`else
  assign w_cpu_press = 1'b0;
`endif

  assign Lpress = w_lpress;
  assign Rpress = w_rpress_key | w_cpu_press;

  // Playfield FSM: state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_PLAY;
      r_pos   <= POS_CENTER;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  // Playfield FSM: next state. gameReset wins over any same-cycle press.
  // Simultaneous presses cancel each other out.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    if (gameReset) begin
      w_state_nxt = ST_PLAY;
      w_pos_nxt   = POS_CENTER;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (Lpress && !Rpress) begin
            if (r_pos < POS_MAX) begin
              w_pos_nxt = r_pos + 4'd1;
            end else begin
              w_state_nxt = ST_LOCK;
            end
          end else if (Rpress && !Lpress) begin
            if (r_pos > 4'd0) begin
              w_pos_nxt = r_pos - 4'd1;
            end else begin
              w_state_nxt = ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          w_state_nxt = ST_LOCK;
        end
        default: begin
          w_state_nxt = ST_PLAY;
          w_pos_nxt   = POS_CENTER;
        end
      endcase
    end
  end

  assign LED         = 9'd1 << r_pos;
  assign P1LED9      = LED[8];
  assign P2LED1      = LED[0];
  assign o_dbg_state = (r_state == ST_LOCK);

endmodule

// File: tb/tb_playfield_ctrl.sv
// -----------------------------------------------------------------------------
// tb_playfield_ctrl
//
// Directed testbench for playfield_ctrl.
// Inputs are driven on the falling clock edge, and outputs are sampled on the
// falling clock edge. The design updates on the rising edge, so every check
// sees settled values.
// When CPU_PLAYER_EN is defined, the bench also runs the CPU-player scenario.
// -----------------------------------------------------------------------------
module tb_playfield_ctrl;

  localparam int P = 64;

  logic       Clock;
  logic       Reset;
  logic       L;
  logic       R;
  logic       gameReset;
  logic [8:0] LED;
  logic       P1LED9;
  logic       P2LED1;
  logic       Lpress;
  logic       Rpress;
  logic       o_dbg_state;
`ifdef CPU_PLAYER_EN
  logic [8:0] SW;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  playfield_ctrl #(.CENTER(4), .CPU_PERIOD(P)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .L           (L),
    .R           (R),
    .gameReset   (gameReset),
`ifdef CPU_PLAYER_EN
    .SW          (SW),
`endif
    .LED         (LED),
    .P1LED9      (P1LED9),
    .P2LED1      (P2LED1),
    .Lpress      (Lpress),
    .Rpress      (Rpress),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- driver tasks ----------------
  // One key press: raise the key for one sample, then release it.
  // lp/rp report the press pulses seen in the pulse cycle.
  // The task returns on the falling edge after the position update.
  task automatic key_pulse(input logic l, input logic r,
                           output logic lp, output logic rp);
    L = l;
    R = r;
    @(negedge Clock);
    L = 1'b0;
    R = 1'b0;
    @(negedge Clock);
    lp = Lpress;
    rp = Rpress;
    @(negedge Clock);
  endtask

  task automatic pulse_game_reset();
    gameReset = 1'b1;
    @(negedge Clock);
    gameReset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge Clock);
    n_checks++;
    if (LED !== 9'h010) begin
      n_fail++;
      $display("FAIL reset_led: got %h expected %h", LED, 9'h010);
    end
    n_checks++;
    if ({P1LED9, P2LED1, Lpress, Rpress, o_dbg_state} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected 00000",
               {P1LED9, P2LED1, Lpress, Rpress, o_dbg_state});
    end
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
  endtask

  task automatic test_hold_l();
    int pulses;
    pulses = 0;
    L = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clock);
      if (Lpress === 1'b1) pulses++;
      n_checks++;
      if (Lpress !== (i == 2)) begin
        n_fail++;
        $display("FAIL hold_l_pulse[%0d]: got %b expected %b", i, Lpress, (i == 2));
      end
      n_checks++;
      if (LED !== ((i >= 3) ? 9'h020 : 9'h010)) begin
        n_fail++;
        $display("FAIL hold_l_led[%0d]: got %h expected %h", i, LED,
                 (i >= 3) ? 9'h020 : 9'h010);
      end
    end
    L = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      if (Lpress === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL hold_l_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_win_left();
    logic lp, rp;
    pulse_game_reset();
    n_checks++;
    if (LED !== 9'h010) begin
      n_fail++;
      $display("FAIL recenter_led: got %h expected %h", LED, 9'h010);
    end
    for (int i = 1; i <= 4; i++) begin
      key_pulse(1'b1, 1'b0, lp, rp);
      n_checks++;
      if ({lp, rp} !== 2'b10 || LED !== (9'h010 << i)) begin
        n_fail++;
        $display("FAIL win_left_step[%0d]: got lp=%b rp=%b led=%h expected lp=1 rp=0 led=%h",
                 i, lp, rp, LED, 9'h010 << i);
      end
    end
    n_checks++;
    if ({P1LED9, P2LED1} !== 2'b10) begin
      n_fail++;
      $display("FAIL p1led9: got P1LED9=%b P2LED1=%b expected 1 0", P1LED9, P2LED1);
    end
    key_pulse(1'b1, 1'b0, lp, rp);
    n_checks++;
    if (lp !== 1'b1 || LED !== 9'h100 || o_dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL win_left_lock: got lp=%b led=%h state=%b expected lp=1 led=100 state=1",
               lp, LED, o_dbg_state);
    end
    key_pulse(1'b0, 1'b1, lp, rp);
    n_checks++;
    if (rp !== 1'b1 || LED !== 9'h100 || o_dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_r_press: got rp=%b led=%h state=%b expected rp=1 led=100 state=1",
               rp, LED, o_dbg_state);
    end
  endtask

  // An R pulse lands in the same cycle as gameReset; the recenter must win.
  task automatic test_game_reset();
    R = 1'b1;
    @(negedge Clock);
    R = 1'b0;
    @(negedge Clock);
    n_checks++;
    if (Rpress !== 1'b1) begin
      n_fail++;
      $display("FAIL greset_rpulse: got %b expected 1", Rpress);
    end
    gameReset = 1'b1;
    @(negedge Clock);
    gameReset = 1'b0;
    n_checks++;
    if (LED !== 9'h010 || o_dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL greset_center: got led=%h state=%b expected led=010 state=0",
               LED, o_dbg_state);
    end
    @(negedge Clock);
    n_checks++;
    if (LED !== 9'h010) begin
      n_fail++;
      $display("FAIL greset_hold: got %h expected %h", LED, 9'h010);
    end
  endtask

  task automatic test_win_right();
    logic lp, rp;
    for (int i = 1; i <= 4; i++) begin
      key_pulse(1'b0, 1'b1, lp, rp);
      n_checks++;
      if ({lp, rp} !== 2'b01 || LED !== (9'h010 >> i)) begin
        n_fail++;
        $display("FAIL win_right_step[%0d]: got lp=%b rp=%b led=%h expected lp=0 rp=1 led=%h",
                 i, lp, rp, LED, 9'h010 >> i);
      end
    end
    n_checks++;
    if ({P1LED9, P2LED1} !== 2'b01) begin
      n_fail++;
      $display("FAIL p2led1: got P1LED9=%b P2LED1=%b expected 0 1", P1LED9, P2LED1);
    end
    key_pulse(1'b0, 1'b1, lp, rp);
    n_checks++;
    if (LED !== 9'h001 || o_dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL win_right_lock: got led=%h state=%b expected led=001 state=1",
               LED, o_dbg_state);
    end
    pulse_game_reset();
    n_checks++;
    if (LED !== 9'h010 || o_dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL win_right_recenter: got led=%h state=%b expected led=010 state=0",
               LED, o_dbg_state);
    end
  endtask

  task automatic test_simultaneous();
    logic lp, rp;
    key_pulse(1'b1, 1'b1, lp, rp);
    n_checks++;
    if ({lp, rp} !== 2'b11 || LED !== 9'h010 || o_dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL simultaneous: got lp=%b rp=%b led=%h state=%b expected 1 1 010 0",
               lp, rp, LED, o_dbg_state);
    end
  endtask

  task automatic test_async_reset();
    logic lp, rp;
    for (int i = 1; i <= 3; i++) key_pulse(1'b1, 1'b0, lp, rp);
    n_checks++;
    if (LED !== 9'h080) begin
      n_fail++;
      $display("FAIL pre_reset_pos7: got %h expected %h", LED, 9'h080);
    end
    // Assert reset between clock edges and hold L down across the release.
    #2;
    Reset = 1'b0;
    L     = 1'b1;
    #1;
    n_checks++;
    if (LED !== 9'h010 || o_dbg_state !== 1'b0 || Lpress !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got led=%h state=%b lp=%b expected 010 0 0",
               LED, o_dbg_state, Lpress);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clock);
      n_checks++;
      if (Lpress !== 1'b0 || LED !== 9'h010) begin
        n_fail++;
        $display("FAIL held_l_release[%0d]: got lp=%b led=%h expected 0 010", i, Lpress, LED);
      end
    end
    L = 1'b0;
    repeat (3) @(negedge Clock);
    key_pulse(1'b1, 1'b0, lp, rp);
    n_checks++;
    if (lp !== 1'b1 || LED !== 9'h020) begin
      n_fail++;
      $display("FAIL post_reset_press: got lp=%b led=%h expected 1 020", lp, LED);
    end
    pulse_game_reset();
  endtask

`ifdef CPU_PLAYER_EN
  // Reference model of the CPU player's LFSR and tick timing.
  logic [9:0] m_lfsr;
  int         m_cnt;
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_lfsr <= 10'h001;
      m_cnt  <= 0;
    end else begin
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      m_cnt  <= (m_cnt == P - 1) ? 0 : m_cnt + 1;
    end
  end

  task automatic test_cpu();
    int   pulses;
    logic exp_r;
    SW     = 9'h1FF;
    pulses = 0;
    for (int i = 0; i < 8 * P; i++) begin
      @(negedge Clock);
      exp_r = (m_cnt == P - 1) && ({1'b0, SW} > m_lfsr);
      if (Rpress === 1'b1) pulses++;
      n_checks++;
      if (Rpress !== exp_r) begin
        n_fail++;
        $display("FAIL cpu_rpress[%0d]: got %b expected %b", i, Rpress, exp_r);
      end
    end
    n_checks++;
    if (pulses == 0) begin
      n_fail++;
      $display("FAIL cpu_any_press: got 0 pulses expected at least 1");
    end
    SW     = 9'h000;
    pulses = 0;
    for (int i = 0; i < 8 * P; i++) begin
      @(negedge Clock);
      if (Rpress === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL cpu_sw0: got %0d pulses expected 0", pulses);
    end
    pulse_game_reset();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    L         = 1'b0;
    R         = 1'b0;
    gameReset = 1'b0;
    Reset     = 1'b0;
`ifdef CPU_PLAYER_EN
    SW        = 9'h000;
`endif
    test_reset();
    test_hold_l();
    test_win_left();
    test_game_reset();
    test_win_right();
    test_simultaneous();
    test_async_reset();
`ifdef CPU_PLAYER_EN
    test_cpu();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/playfield_ctrl.md
PLAYFIELD_CTRL -- requirements
Module: playfield_ctrl

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; ports are named Clock and Reset as elsewhere in the codebase.
REQ-002 SHALL have parameter CENTER, default 4: light position after reset or recenter, legal range 1..7.
REQ-003 SHALL have parameter CPU_PERIOD, default 1024: cycles between CPU press attempts; used only with CPU_PLAYER_EN.
REQ-004 SHALL have port Clock, input, 1 bit: rising-edge system clock.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-low.
REQ-006 SHALL have port L, input, 1 bit: raw left-player key, high = pressed, asynchronous to Clock.
REQ-007 SHALL have port R, input, 1 bit: raw right-player key, high = pressed, asynchronous to Clock.
REQ-008 SHALL have port gameReset, input, 1 bit: one-cycle recenter request from the win/score block.
REQ-009 SHALL have port LED, output, 9 bits: one-hot playfield; LED[8] = leftmost (LEDR9), LED[0] = rightmost (LEDR1).
REQ-010 SHALL have port P1LED9, output, 1 bit: equal to LED[8].
REQ-011 SHALL have port P2LED1, output, 1 bit: equal to LED[0].
REQ-012 SHALL have port Lpress, output, 1 bit: conditioned one-cycle left press pulse, fed to the win block's L input.
REQ-013 SHALL have port Rpress, output, 1 bit: conditioned one-cycle right press pulse (includes CPU presses), fed to the win block's R input.
REQ-014 SHALL have port SW, input, 9 bits: CPU difficulty; present only with CPU_PLAYER_EN.

Function
REQ-015 SHALL pass each raw key through a 2-flop synchronizer followed by a rising-edge detector (sync2 & ~prev).
REQ-016 Key timing SHALL be: raw key sampled high at edge n -> press pulse high for exactly the cycle between edges n+1 and n+2 -> position updated at edge n+2.
REQ-017 A held key SHALL produce exactly one pulse; the key must be released (sampled low) before it can pulse again.
REQ-018 SHALL hold position pos in range 0..8 (4 bits) and drive LED = 1 << pos; exactly one LED is lit at all times.
REQ-019 FSM SHALL have states PLAY and LOCK.
REQ-020 In PLAY, Lpress & ~Rpress SHALL give pos+1 when pos<8; at pos==8 pos holds and the FSM goes to LOCK (winning press).
REQ-021 In PLAY, Rpress & ~Lpress SHALL give pos-1 when pos>0; at pos==0 pos holds and the FSM goes to LOCK.
REQ-022 Simultaneous Lpress & Rpress SHALL leave pos and state unchanged.
REQ-023 In LOCK, presses SHALL NOT change pos; the Lpress/Rpress outputs still pulse.
REQ-024 gameReset high at an edge SHALL set pos=CENTER and state=PLAY in any state, overriding any same-cycle press.
REQ-025 No wrap-around: pos SHALL never go below 0 or above 8.

Reset
REQ-026 While Reset is low: pos=CENTER, LED=9'b000010000 (default CENTER), state=PLAY, synchronizer and edge flops=0, Lpress=Rpress=0, P1LED9=P2LED1=0.
REQ-027 Reset assertion SHALL act immediately, without a clock edge; it SHALL release synchronously, so the first state change occurs at the first edge after Reset goes high.
REQ-028 A key held through reset release SHALL NOT produce a press pulse, because prev is loaded before the pulse is enabled.

Configuration
REQ-029 With macro CPU_PLAYER_EN defined, the SW port SHALL exist, and the block SHALL contain a 10-bit Fibonacci LFSR (taps 10,7; seed 10'h001 at reset) stepping every cycle and a tick counter wrapping every CPU_PERIOD cycles.
REQ-030 With CPU_PLAYER_EN defined, on a tick cycle where {1'b0,SW} > LFSR, a one-cycle CPU press SHALL be ORed into Rpress, with the same position timing as a key pulse.
REQ-031 With CPU_PLAYER_EN defined, SW=0 SHALL produce no CPU presses.
REQ-032 Without CPU_PLAYER_EN, the SW port, LFSR and tick counter SHALL be absent, and Rpress SHALL come from R only.

Verification
REQ-033 Reset low, then high; hold L for 5 cycles -> exactly one Lpress pulse, LED 9'h010 -> 9'h020 two edges after L is sampled.
REQ-034 Press L 4 times from center -> LED=9'h100, P1LED9=1; a 5th L press -> state LOCK, LED unchanged; further R press -> LED unchanged.
REQ-035 From LOCK, pulse gameReset -> next edge LED=9'h010, state PLAY; R press in the same cycle as gameReset -> ignored.
REQ-036 L and R raised in the same cycle -> Lpress and Rpress both pulse, LED unchanged.
REQ-037 Reset asserted mid-game at pos=7 with no clock -> LED=9'h010 immediately; L held across reset release -> no pulse.
REQ-038 CPU_PLAYER_EN defined, SW=9'h1FF, 8*CPU_PERIOD cycles -> Rpress pulses only on tick cycles; SW=0 -> zero Rpress pulses.
